// File: rtl/pipe_pkg.sv
// Shared types for the skid-buffered pipeline stage: occupancy-encoded state and control bit indices.
package pipe_pkg;

   // Encoding equals the number of held entries, so it doubles as the occupancy output.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      BUSY  = 2'd1,
      FULL  = 2'd2
   } state_e;

   localparam int unsigned CTRL_WREG  = 0;
   localparam int unsigned CTRL_M2REG = 1;
   localparam int unsigned CTRL_WMEM  = 2;

endpackage

// File: rtl/pipe_slot.sv
// One storage slot of the pipeline stage: {ctrl, data, rn} with load enable and a ctrl-only clear.
module pipe_slot #(
   parameter int unsigned CTRL_W = 3,
   parameter int unsigned DATA_W = 64,
   parameter int unsigned RN_W   = 5
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              load_i,
   input  logic              clr_ctrl_i,
   input  logic [CTRL_W-1:0] ctrl_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic [RN_W-1:0]   rn_i,
   output logic [CTRL_W-1:0] ctrl_o,
   output logic [DATA_W-1:0] data_o,
   output logic [RN_W-1:0]   rn_o
);

   logic [CTRL_W-1:0] ctrl_q;
   logic [DATA_W-1:0] data_q;
   logic [RN_W-1:0]   rn_q;

   // Clearing ctrl turns the slot into a bubble; data and rn are left as they were.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ctrl_q <= '0;
         data_q <= '0;
         rn_q   <= '0;
      end else if (clr_ctrl_i) begin
         ctrl_q <= '0;
      end else if (load_i) begin
         ctrl_q <= ctrl_i;
         data_q <= data_i;
         rn_q   <= rn_i;
      end
   end

   assign ctrl_o = ctrl_q;
   assign data_o = data_q;
   assign rn_o   = rn_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake, 2-entry skid buffer, flush and stall counter.
module pipe_stage_skid
   import pipe_pkg::*;
#(
   parameter int unsigned CTRL_W = 3,
   parameter int unsigned DATA_W = 64,
   parameter int unsigned RN_W   = 5,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   input  logic [RN_W-1:0]   in_rn,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data,
   output logic [RN_W-1:0]   out_rn,
   output logic [1:0]        occupancy,
   output logic [CNT_W-1:0]  stall_cnt
);

   state_e state_q, state_d;
   logic   in_fire, out_fire;
   logic   main_load, skid_load, main_sel_skid;

   logic [CTRL_W-1:0] main_ctrl, skid_ctrl, main_ctrl_d;
   logic [DATA_W-1:0] main_data, skid_data, main_data_d;
   logic [RN_W-1:0]   main_rn, skid_rn, main_rn_d;

   logic [CNT_W-1:0] stall_q, stall_d;

   // Handshake flags come from the state register alone, so out_ready never reaches in_ready.
   assign in_ready  = (state_q != FULL);
   assign out_valid = (state_q != EMPTY);
   assign in_fire   = in_valid & in_ready;
   assign out_fire  = out_valid & out_ready;

   always_comb begin
      state_d       = state_q;
      main_load     = 1'b0;
      skid_load     = 1'b0;
      main_sel_skid = 1'b0;
      if (flush) begin
         state_d = EMPTY;
      end else begin
         unique case (state_q)
            EMPTY: begin
               if (in_fire) begin
                  state_d   = BUSY;
                  main_load = 1'b1;
               end
            end
            BUSY: begin
               if (in_fire && out_fire) begin
                  main_load = 1'b1;
               end else if (in_fire) begin
                  state_d   = FULL;
                  skid_load = 1'b1;
               end else if (out_fire) begin
                  state_d = EMPTY;
               end
            end
            FULL: begin
               if (out_fire) begin
                  state_d       = BUSY;
                  main_load     = 1'b1;
                  main_sel_skid = 1'b1;
               end
            end
            default: state_d = EMPTY;
         endcase
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      main_ctrl_d = main_sel_skid ? skid_ctrl : in_ctrl;
      main_data_d = main_sel_skid ? skid_data : in_data;
      main_rn_d   = main_sel_skid ? skid_rn   : in_rn;
   end

   pipe_slot #(
      .CTRL_W (CTRL_W),
      .DATA_W (DATA_W),
      .RN_W   (RN_W)
   ) u_main (
      .clk_i      (clock),
      .rst_i      (reset),
      .load_i     (main_load),
      .clr_ctrl_i (flush),
      .ctrl_i     (main_ctrl_d),
      .data_i     (main_data_d),
      .rn_i       (main_rn_d),
      .ctrl_o     (main_ctrl),
      .data_o     (main_data),
      .rn_o       (main_rn)
   );

   pipe_slot #(
      .CTRL_W (CTRL_W),
      .DATA_W (DATA_W),
      .RN_W   (RN_W)
   ) u_skid (
      .clk_i      (clock),
      .rst_i      (reset),
      .load_i     (skid_load),
      .clr_ctrl_i (flush),
      .ctrl_i     (in_ctrl),
      .data_i     (in_data),
      .rn_i       (in_rn),
      .ctrl_o     (skid_ctrl),
      .data_o     (skid_data),
      .rn_o       (skid_rn)
   );

   always_comb begin
      stall_d = stall_q;
      if (out_valid && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
         stall_d = stall_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         stall_q <= '0;
      end else begin
         stall_q <= stall_d;
      end
   end

   // Gating ctrl keeps wreg/wmem low downstream whenever the stage holds a bubble.
   assign out_ctrl  = out_valid ? main_ctrl : '0;
   assign out_data  = main_data;
   assign out_rn    = main_rn;
   assign occupancy = state_q;
   assign stall_cnt = stall_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid: directed scenarios plus a randomized run against a queue model.
module tb_pipe_stage_skid;

   localparam int unsigned CTRL_W  = 3;
   localparam int unsigned DATA_W  = 64;
   localparam int unsigned RN_W    = 5;
   localparam int unsigned CNT_W   = 4;
   localparam int unsigned ENT_W   = CTRL_W + DATA_W + RN_W;
   localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

   logic              clock     = 1'b0;
   logic              reset     = 1'b1;
   logic              flush     = 1'b0;
   logic              in_valid  = 1'b0;
   logic              out_ready = 1'b0;
   logic [CTRL_W-1:0] in_ctrl   = '0;
   logic [DATA_W-1:0] in_data   = '0;
   logic [RN_W-1:0]   in_rn     = '0;
   logic              in_ready;
   logic              out_valid;
   logic [CTRL_W-1:0] out_ctrl;
   logic [DATA_W-1:0] out_data;
   logic [RN_W-1:0]   out_rn;
   logic [1:0]        occupancy;
   logic [CNT_W-1:0]  stall_cnt;

   int tests = 0;
   int fails = 0;

   // Reference model: a FIFO of capacity 2 whose accept/present flags reflect the pre-edge count.
   logic [ENT_W-1:0] m_q[$];
   int unsigned      m_cnt = 0;
   bit               m_ov;
   bit               m_ir;

   pipe_stage_skid #(
      .CTRL_W (CTRL_W),
      .DATA_W (DATA_W),
      .RN_W   (RN_W),
      .CNT_W  (CNT_W)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_ctrl   (in_ctrl),
      .in_data   (in_data),
      .in_rn     (in_rn),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_ctrl  (out_ctrl),
      .out_data  (out_data),
      .out_rn    (out_rn),
      .occupancy (occupancy),
      .stall_cnt (stall_cnt)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [ENT_W-1:0] act, input logic [ENT_W-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clock or posedge reset) begin
      if (reset) begin
         m_q.delete();
         m_cnt = 0;
      end else begin
         m_ov = (m_q.size() > 0);
         m_ir = (m_q.size() < 2);
         if (m_ov && !out_ready && m_cnt < CNT_MAX) m_cnt++;
         if (flush) begin
            m_q.delete();
         end else begin
            if (m_ov && out_ready) void'(m_q.pop_front());
            if (in_valid && m_ir) m_q.push_back({in_ctrl, in_data, in_rn});
         end
      end
   end

   always @(negedge clock) begin
      if (!reset) begin
         check("in_ready", ENT_W'(in_ready), ENT_W'(m_q.size() < 2));
         check("out_valid", ENT_W'(out_valid), ENT_W'(m_q.size() > 0));
         check("occupancy", ENT_W'(occupancy), ENT_W'(m_q.size()));
         check("stall_cnt", ENT_W'(stall_cnt), ENT_W'(m_cnt));
         check("ready_vs_occ", ENT_W'(in_ready), ENT_W'(occupancy != 2'd2));
         if (m_q.size() > 0) check("head", {out_ctrl, out_data, out_rn}, m_q[0]);
         else check("bubble_ctrl", ENT_W'(out_ctrl), '0);
      end
   end

   task automatic idle_inputs();
      in_valid  = 1'b0;
      flush     = 1'b0;
      out_ready = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clock);
      idle_inputs();
      #1 reset = 1'b1;
      @(negedge clock);
      #1 reset = 1'b0;
   endtask

   task automatic push(input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d,
                       input logic [RN_W-1:0] r);
      in_valid = 1'b1;
      in_ctrl  = c;
      in_data  = d;
      in_rn    = r;
   endtask

   initial begin
      repeat (2) @(negedge clock);
      #1 reset = 1'b0;

      // 1: fill to FULL, then reset mid-operation
      @(negedge clock); #1 push(3'b001, 64'hA1, 5'd1);
      @(negedge clock); #1 push(3'b001, 64'hA2, 5'd2);
      @(negedge clock);
      check("t1_full", ENT_W'(occupancy), ENT_W'(2));
      do_reset();
      @(negedge clock);
      check("t1_valid", ENT_W'(out_valid), '0);
      check("t1_occ", ENT_W'(occupancy), '0);
      check("t1_ready", ENT_W'(in_ready), ENT_W'(1));
      check("t1_ctrl", ENT_W'(out_ctrl), '0);
      check("t1_data", ENT_W'(out_data), '0);
      check("t1_stall", ENT_W'(stall_cnt), '0);

      // 2: streaming at full throughput
      #1 out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         push(3'b001, DATA_W'(i), RN_W'(i));
         @(negedge clock);
         check("t2_data", ENT_W'(out_data), ENT_W'(i));
         check("t2_rn", ENT_W'(out_rn), ENT_W'(i));
         check("t2_occ", ENT_W'(occupancy), ENT_W'(1));
         #1;
      end
      in_valid = 1'b0;
      @(negedge clock);
      check("t2_stall", ENT_W'(stall_cnt), '0);
      check("t2_drained", ENT_W'(out_valid), '0);

      // 3: backpressure fills skid, third push blocked, then ordered drain
      do_reset();
      #1 push(3'b001, 64'h11, 5'd3);
      @(negedge clock);
      check("t3_occ1", ENT_W'(occupancy), ENT_W'(1));
      #1 push(3'b001, 64'h22, 5'd4);
      @(negedge clock);
      check("t3_occ2", ENT_W'(occupancy), ENT_W'(2));
      check("t3_ready", ENT_W'(in_ready), '0);
      check("t3_a", ENT_W'(out_data), ENT_W'(64'h11));
      #1 push(3'b001, 64'h44, 5'd5);
      @(negedge clock);
      check("t3_blocked", ENT_W'(occupancy), ENT_W'(2));
      check("t3_a_held", ENT_W'(out_data), ENT_W'(64'h11));
      #1 out_ready = 1'b1;
      @(negedge clock);
      check("t3_b", ENT_W'(out_data), ENT_W'(64'h22));
      @(negedge clock);
      check("t3_c", ENT_W'(out_data), ENT_W'(64'h44));
      #1 in_valid = 1'b0;
      @(negedge clock);
      check("t3_empty", ENT_W'(occupancy), '0);

      // 4: flush from FULL and from BUSY discards held and incoming entries
      do_reset();
      #1 push(3'b101, 64'h55, 5'd6);
      @(negedge clock); #1 push(3'b101, 64'h66, 5'd7);
      @(negedge clock);
      check("t4_ctrl_full", ENT_W'(out_ctrl), ENT_W'(3'b101));
      #1 flush = 1'b1; push(3'b101, 64'h33, 5'd8);
      @(negedge clock);
      check("t4_valid", ENT_W'(out_valid), '0);
      check("t4_ctrl", ENT_W'(out_ctrl), '0);
      check("t4_occ", ENT_W'(occupancy), '0);
      #1 flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      repeat (3) begin
         @(negedge clock);
         check("t4_no33", ENT_W'(out_valid), '0);
      end
      #1 out_ready = 1'b0; push(3'b001, 64'h77, 5'd9);
      @(negedge clock);
      check("t4_busy", ENT_W'(occupancy), ENT_W'(1));
      #1 flush = 1'b1; push(3'b101, 64'h33, 5'd10);
      @(negedge clock);
      check("t4_busy_flush", ENT_W'(occupancy), '0);
      #1 flush = 1'b0; in_valid = 1'b0;
      @(negedge clock);
      check("t4_busy_no33", ENT_W'(out_valid), '0);

      // 5: stall counter saturation
      do_reset();
      #1 push(3'b001, 64'h99, 5'd11);
      @(negedge clock);
      #1 in_valid = 1'b0;
      repeat (5) @(negedge clock);
      check("t5_cnt5", ENT_W'(stall_cnt), ENT_W'(5));
      repeat (15) @(negedge clock);
      check("t5_sat", ENT_W'(stall_cnt), ENT_W'(15));
      #1 out_ready = 1'b1;
      @(negedge clock);
      check("t5_sat_hold", ENT_W'(stall_cnt), ENT_W'(15));

      // 6: randomized traffic with occasional flushes
      do_reset();
      for (int n = 0; n < 10000; n++) begin
         #1;
         in_valid  = ($urandom_range(0, 99) < 60);
         out_ready = ($urandom_range(0, 99) < 55);
         flush     = ($urandom_range(0, 99) < 3);
         in_ctrl   = CTRL_W'($urandom);
         in_data   = {$urandom, $urandom};
         in_rn     = RN_W'($urandom);
         @(negedge clock);
      end
      #1 idle_inputs();
      @(negedge clock);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
